alu_sched: RTL and testbench
============================

# alu_sched

Two-requester scheduler sharing one 4-bit combinational ALU datapath. It accepts operation requests (A, B, op select) on independent valid/ready ports, grants one at a time, and drives the shared ALU's operand/select lines. It registers the ALU result and flags and returns them on the winning requester's response port. It sits between the ALU and its client blocks, so the ALU itself stays purely combinational.

## Interface
- Parameters:
- `W`, 4: operand/result width; must match the ALU datapath.
- `N_REQ`, 2: number of requesters; fixed at 2 in this revision.
- Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  N_REQ  per-requester request valid.
- `req_ready`  out  N_REQ  per-requester accept, one-hot or zero.
- `req_a`  in  N_REQ*W  operand A per requester; requester i occupies bits [i*W +: W].
- `req_b`  in  N_REQ*W  operand B per requester, same packing.
- `req_op`  in  N_REQ*3  op select per requester, encoding as ALU `sel` (000 ADD … 111 SHR).
- `rsp_valid`  out  N_REQ  per-requester response valid.
- `rsp_ready`  in  N_REQ  per-requester response accept.
- `rsp_result`  out  W  registered result, shared by both response ports.
- `rsp_carry`  out  1  registered carry/borrow.
- `rsp_zero`  out  1  registered zero flag.
- `alu_a`, `alu_b`  out  W  to ALU operands.
- `alu_sel`  out  3  to ALU select.
- `alu_result`  in  W  from ALU.
- `alu_carry`, `alu_zero`  in  1  from ALU.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any `req_valid` is high, the arbiter picks winner g.
  - `req_ready[g]`=1 combinationally in the same cycle; the handshake completes.
  - Operands and op are captured into internal registers, owner is set to g, and the FSM moves to EXEC.
  - With no valid, the FSM stays in IDLE and `req_ready`=0.
- EXEC:
  - `alu_a`/`alu_b`/`alu_sel` are driven from the captured registers.
  - At the cycle end, `alu_result`/`alu_carry`/`alu_zero` are registered into the `rsp_*` outputs, and the FSM moves to RESP.
- RESP:
  - `rsp_valid[owner]`=1 and the other bit is 0.
  - When `rsp_ready[owner]`=1, the FSM returns to IDLE.
  - Otherwise it holds, with all `rsp_*` stable.
- `req_ready` is 0 in EXEC and RESP. No request is accepted while one is in flight.
- ALU drive lines keep their last value outside EXEC and are 0 after reset.
- Requesters must hold `req_valid` and their payload stable until `req_ready`. The block does not check this.
- Flags are passed through unmodified; ops other than ADD/SUB return the ALU's carry, which is 0.

## Timing
- Accept at cycle T, `rsp_valid` high from T+2.
- Minimum issue interval is 3 cycles (T, T+1, T+2 with `rsp_ready` already high).
- Reset values:
  - State IDLE.
  - `req_ready`=0, `rsp_valid`=0.
  - `rsp_result`=0, `rsp_carry`=0, `rsp_zero`=0.
  - `alu_a`/`alu_b`/`alu_sel`=0.
  - Round-robin pointer favours requester 0.
- Simultaneous valids: one grant per IDLE cycle; the loser waits and is granted at the next IDLE.
- Round-robin pointer updates at grant, not at response completion.
- Unbounded `rsp_ready` stall holds RESP indefinitely; no timeout.
- `rst_n` asserted mid-EXEC or mid-RESP:
  - The in-flight op is discarded and no response is delivered.
  - All outputs go to reset values immediately, asynchronously.
- Deassertion of `rst_n` is synchronised externally; first legal accept is on the first rising edge after release.

## Configuration
- `ALU_SCHED_RR_EN` defined: round-robin arbitration. After granting i, requester 1-i has priority at the next contention.
- Not defined: fixed priority, requester 0 always wins contention. The pointer register is not built.

## Structure
- Shared package `alu_pkg`:
  - op encoding localparams (OP_ADD … OP_SHR).
  - FSM state typedef/localparams (ST_IDLE, ST_EXEC, ST_RESP).
  - default `W`.
- Sub-module `alu_sched_arb`:
  - 2-input arbiter: valid vector in, one-hot grant out.
  - Pointer update on grant strobe.
  - `ALU_SCHED_RR_EN` handled inside it.
- The ALU is not instantiated inside; it connects at the parent level.

## Test plan
- Req0 ADD a=9, b=8 alone, bench ALU connected -> `rsp_valid[0]` at T+2; result=4'h1, carry=1, zero=0.
- Req1 SUB a=3, b=5 -> result=4'hE, carry=1, on `rsp_valid[1]` only; `rsp_valid[0]` stays 0.
- Both requesters valid continuously, XOR ops, `ALU_SCHED_RR_EN` defined -> grants alternate 0,1,0,1. Without the macro, requester 0 is granted every time.
- `rsp_ready[0]` low 5 cycles in RESP -> `rsp_*` held constant, `req_ready`=0 throughout, req1 accepted only after the response handshake.
- AND a=4'hA, b=4'h5 -> result=0, zero=1, carry=0.
- `rst_n` pulsed low during EXEC -> all outputs 0 immediately, no `rsp_valid` afterward; a new request then completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the two-requester ALU scheduler.
//   - OP_* : ALU select encoding driven on alu_sel / carried on req_op
//   - state_e : scheduler FSM states
//   - W_DEFAULT : default operand/result width
//   - owner_onehot : owner index to response-valid vector
package alu_pkg;

  localparam int W_DEFAULT = 4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic [1:0] owner_onehot(input logic owner);
    return owner ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_sched_arb.sv
// alu_sched_arb: 2-input arbiter for the ALU scheduler.
//   valid    : request vector
//   grant    : one-hot (or zero) grant, combinational from valid
//   clk/rst_n/grant_en : only present with ALU_SCHED_RR_EN; grant_en
//                        qualifies the pointer update at a real grant
// Build option ALU_SCHED_RR_EN: round-robin (after granting i, 1-i wins the
// next contention). Without it, requester 0 always wins and no pointer
// register exists.
module alu_sched_arb
  import alu_pkg::*;
(
`ifdef ALU_SCHED_RR_EN
  input  logic       clk,
  input  logic       rst_n,
  input  logic       grant_en,
`endif
  input  logic [1:0] valid,
  output logic [1:0] grant
);

`ifdef ALU_SCHED_RR_EN
  // prio_q = 1 means requester 1 wins a contention; reset favours requester 0
  logic prio_q;
  logic prio_d;

  always_comb begin
    grant = 2'b00;
    if (prio_q) begin
      grant[1] = valid[1];
      grant[0] = valid[0] & ~valid[1];
    end else begin
      grant[0] = valid[0];
      grant[1] = valid[1] & ~valid[0];
    end
  end

  // Pointer moves at grant time, independent of when the response completes
  always_comb begin
    prio_d = prio_q;
    if (grant_en && (grant != 2'b00)) prio_d = grant[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prio_q <= 1'b0;
    else        prio_q <= prio_d;
  end
`else
  always_comb begin
    grant[0] = valid[0];
    grant[1] = valid[1] & ~valid[0];
  end
`endif

endmodule

// File: rtl/alu_sched.sv
// alu_sched: schedules two requesters onto one external combinational ALU.
//   req_*      : per-requester valid/ready request ports (packed i*W +: W)
//   rsp_*      : per-requester response valid/ready, shared result/flags
//   alu_a/b/sel: drive lines to the ALU; alu_result/carry/zero come back
// Flow: IDLE accepts one request and captures it, EXEC drives the ALU and
// registers its outputs, RESP presents them until the owner accepts.
// Build option ALU_SCHED_RR_EN selects round-robin arbitration (see
// alu_sched_arb); default is fixed priority to requester 0.
module alu_sched
  import alu_pkg::*;
#(
  parameter int W     = W_DEFAULT,
  parameter int N_REQ = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  input  logic [N_REQ*3-1:0] req_op,
  output logic [N_REQ-1:0]   rsp_valid,
  input  logic [N_REQ-1:0]   rsp_ready,
  output logic [W-1:0]       rsp_result,
  output logic               rsp_carry,
  output logic               rsp_zero,
  output logic [W-1:0]       alu_a,
  output logic [W-1:0]       alu_b,
  output logic [2:0]         alu_sel,
  input  logic [W-1:0]       alu_result,
  input  logic               alu_carry,
  input  logic               alu_zero
);

  state_e       state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]   op_q, op_d;
  logic         owner_q, owner_d;
  logic [W-1:0] res_q, res_d;
  logic         carry_q, carry_d;
  logic         zero_q, zero_d;
  logic [1:0]   grant;

  alu_sched_arb u_arb (
`ifdef ALU_SCHED_RR_EN
    .clk      (clk),
    .rst_n    (rst_n),
    .grant_en (state_q == ST_IDLE),
`endif
    .valid    (req_valid),
    .grant    (grant)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    owner_d   = owner_q;
    res_d     = res_q;
    carry_d   = carry_q;
    zero_d    = zero_q;
    req_ready = '0;
    rsp_valid = '0;
    case (state_q)
      ST_IDLE: begin
        req_ready = grant;
        if (grant != 2'b00) begin
          owner_d = grant[1];
          if (grant[1]) begin
            a_d  = req_a[W +: W];
            b_d  = req_b[W +: W];
            op_d = req_op[3 +: 3];
          end else begin
            a_d  = req_a[0 +: W];
            b_d  = req_b[0 +: W];
            op_d = req_op[0 +: 3];
          end
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        res_d   = alu_result;
        carry_d = alu_carry;
        zero_d  = alu_zero;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = owner_onehot(owner_q);
        if (rsp_ready[owner_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      owner_q <= 1'b0;
      res_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      owner_q <= owner_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  // Capture registers only change at accept, so they also hold the ALU
  // lines at their last value outside EXEC.
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_sel    = op_q;
  assign rsp_result = res_q;
  assign rsp_carry  = carry_q;
  assign rsp_zero   = zero_q;

endmodule

// File: tb/tb_alu_sched.sv
module tb_alu_sched;
  import alu_pkg::*;

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
  } req_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req_valid = 2'b00;
  logic [1:0] req_ready;
  logic [7:0] req_a = 8'h0;
  logic [7:0] req_b = 8'h0;
  logic [5:0] req_op = 6'h0;
  logic [1:0] rsp_valid;
  logic [1:0] rsp_ready = 2'b11;
  logic [3:0] rsp_result;
  logic       rsp_carry, rsp_zero;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_sel;
  logic [3:0] alu_result;
  logic       alu_carry, alu_zero;

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;
  int acc_cyc [2];
  logic [1:0] hs_q = 2'b00;
  req_t q0[$];
  req_t q1[$];
  int grant_log[$];

  // reference model state
  int         m_phase = 0;
  logic       m_owner = 1'b0;
  logic       m_last = 1'b1;
  logic [3:0] m_a = 0, m_b = 0;
  logic [2:0] m_op = 0;
  logic [3:0] m_res = 0;
  logic       m_c = 0, m_z = 0;

  always #5 clk = ~clk;

  alu_sched dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero)
  );

  // Returns {carry, zero, result}
  function automatic logic [5:0] alu_ref(input logic [2:0] op, input logic [3:0] a,
                                         input logic [3:0] b);
    logic [4:0] s;
    logic [3:0] r;
    logic       c;
    c = 1'b0;
    case (op)
      OP_ADD: begin s = {1'b0, a} + {1'b0, b}; r = s[3:0]; c = s[4]; end
      OP_SUB: begin r = a - b; c = (a < b); end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_NOT: r = ~a;
      OP_SHL: r = a << 1;
      default: r = a >> 1;
    endcase
    return {c, (r == 4'h0), r};
  endfunction

  logic [5:0] alu_out;
  assign alu_out    = alu_ref(alu_sel, alu_a, alu_b);
  assign alu_result = alu_out[3:0];
  assign alu_zero   = alu_out[4];
  assign alu_carry  = alu_out[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // handshake capture for the requester drivers
  always @(posedge clk) begin
    cyc <= cyc + 1;
    hs_q <= req_valid & req_ready & {2{rst_n}};
    for (int i = 0; i < 2; i++)
      if (req_valid[i] && req_ready[i] && rst_n) acc_cyc[i] <= cyc;
  end

  // requester drivers: hold valid/payload until accepted, then take next item
  always @(negedge clk) begin
    req_t r;
    for (int i = 0; i < 2; i++) begin
      if (req_valid[i] && hs_q[i]) req_valid[i] = 1'b0;
      if (!req_valid[i] && ((i == 0) ? q0.size() : q1.size()) > 0) begin
        r = (i == 0) ? q0.pop_front() : q1.pop_front();
        req_a[i*4 +: 4]  = r.a;
        req_b[i*4 +: 4]  = r.b;
        req_op[i*3 +: 3] = r.op;
        req_valid[i]     = 1'b1;
      end
    end
  end

  // compare process: predicts every output from the block's rules each cycle
  always @(negedge clk) begin
    logic [1:0] exp_rdy;
    logic [5:0] ref_v;
    int w;
    #1;
    if (!rst_n) begin
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_result", {rsp_carry, rsp_zero, rsp_result}, 0);
      check("rst_alu", {alu_a, alu_b, alu_sel}, 0);
      m_phase = 0; m_owner = 0; m_last = 1'b1;
      m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_c = 0; m_z = 0;
    end else begin
      exp_rdy = 2'b00;
      w = 0;
      if (m_phase == 0 && req_valid != 2'b00) begin
        if (req_valid == 2'b11) begin
`ifdef ALU_SCHED_RR_EN
          w = m_last ? 0 : 1;
`else
          w = 0;
`endif
        end else begin
          w = req_valid[0] ? 0 : 1;
        end
        exp_rdy = (w == 0) ? 2'b01 : 2'b10;
      end
      check("req_ready", req_ready, exp_rdy);
      check("rsp_valid", rsp_valid, (m_phase == 2) ? (m_owner ? 2'b10 : 2'b01) : 2'b00);
      check("rsp_data", {rsp_carry, rsp_zero, rsp_result}, {m_c, m_z, m_res});
      check("alu_lines", {alu_a, alu_b, alu_sel}, {m_a, m_b, m_op});
      if (m_phase == 0) begin
        if (exp_rdy != 2'b00) begin
          m_a = req_a[w*4 +: 4];
          m_b = req_b[w*4 +: 4];
          m_op = req_op[w*3 +: 3];
          m_owner = (w == 1);
          m_last = (w == 1);
          grant_log.push_back(w);
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        ref_v = alu_ref(m_op, m_a, m_b);
        m_res = ref_v[3:0]; m_z = ref_v[4]; m_c = ref_v[5];
        m_phase = 2;
      end else begin
        if (rsp_ready[m_owner]) m_phase = 0;
      end
    end
  end

  task automatic wait_rsp(input int i);
    bit got;
    got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk); #2;
      if (rsp_valid[i]) got = 1;
    end
    if (!got) check("wait_rsp_timeout", 0, 1);
  endtask

  task automatic wait_hs(input int i);
    bit got;
    got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk); #2;
      if (hs_q[i]) got = 1;
    end
    if (!got) check("wait_hs_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit got;
    got = 0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk); #2;
      if (q0.size() == 0 && q1.size() == 0 && req_valid == 2'b00 && m_phase == 0) got = 1;
    end
    if (!got) check("wait_idle_timeout", 0, 1);
  endtask

  initial begin
    int base;
    int exp_log [8];
    // model pins
    check("ref_add", alu_ref(OP_ADD, 4'h9, 4'h8), {1'b1, 1'b0, 4'h1});
    check("ref_sub", alu_ref(OP_SUB, 4'h3, 4'h5), {1'b1, 1'b0, 4'hE});
    check("ref_and", alu_ref(OP_AND, 4'hA, 4'h5), {1'b0, 1'b1, 4'h0});

    // reset values
    repeat (3) @(negedge clk);
    #2;
    check("reset_rsp_valid", rsp_valid, 2'b00);
    check("reset_req_ready", req_ready, 2'b00);
    check("reset_result", rsp_result, 4'h0);
    check("reset_alu_a", alu_a, 4'h0);
    #1 rst_n = 1'b1;

    // ADD 9+8 on requester 0: response two cycles after accept
    q0.push_back('{op: OP_ADD, a: 4'h9, b: 4'h8});
    wait_rsp(0);
    check("add_latency", cyc - acc_cyc[0], 2);
    check("add_valid", rsp_valid, 2'b01);
    check("add_result", rsp_result, 4'h1);
    check("add_carry", rsp_carry, 1'b1);
    check("add_zero", rsp_zero, 1'b0);
    wait_idle();

    // SUB 3-5 on requester 1
    q1.push_back('{op: OP_SUB, a: 4'h3, b: 4'h5});
    wait_rsp(1);
    check("sub_valid", rsp_valid, 2'b10);
    check("sub_result", rsp_result, 4'hE);
    check("sub_carry", rsp_carry, 1'b1);
    wait_idle();

    // AND giving zero
    q0.push_back('{op: OP_AND, a: 4'hA, b: 4'h5});
    wait_rsp(0);
    check("and_result", {rsp_carry, rsp_zero, rsp_result}, {1'b0, 1'b1, 4'h0});
    wait_idle();

    // response stall on requester 0 while requester 1 waits
    base = grant_log.size();
    @(negedge clk);
    rsp_ready = 2'b10;
    q0.push_back('{op: OP_OR, a: 4'h5, b: 4'h3});
    wait_hs(0);
    q1.push_back('{op: OP_ADD, a: 4'h1, b: 4'h1});
    wait_rsp(0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #2;
      check("stall_result", rsp_result, 4'h7);
      check("stall_valid", rsp_valid, 2'b01);
      check("stall_req_ready", req_ready, 2'b00);
    end
    check("stall_no_grant", grant_log.size() - base, 1);
    @(negedge clk);
    rsp_ready = 2'b11;
    wait_rsp(1);
    check("after_stall_result", rsp_result, 4'h2);
    check("after_stall_order", grant_log[base + 1], 1);
    wait_idle();

    // contention: both requesters keep XOR requests pending
    grant_log.delete();
    for (int k = 0; k < 4; k++) begin
      q0.push_back('{op: OP_XOR, a: 4'hC, b: 4'(k)});
      q1.push_back('{op: OP_XOR, a: 4'h3, b: 4'(k)});
    end
    wait_rsp(0);
    check("xor_first_result", rsp_result, 4'hC);
    wait_idle();
`ifdef ALU_SCHED_RR_EN
    exp_log = '{0, 1, 0, 1, 0, 1, 0, 1};
`else
    exp_log = '{0, 0, 0, 0, 1, 1, 1, 1};
`endif
    check("contention_count", grant_log.size(), 8);
    for (int k = 0; k < 8 && k < grant_log.size(); k++)
      check("contention_order", grant_log[k], exp_log[k]);

    // reset pulse during EXEC discards the in-flight op
    q0.push_back('{op: OP_ADD, a: 4'h2, b: 4'h3});
    wait_hs(0);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_outputs", {req_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero}, 0);
    check("async_rst_alu", {alu_a, alu_b, alu_sel}, 0);
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #2;
      check("no_rsp_after_rst", rsp_valid, 2'b00);
    end
    q0.push_back('{op: OP_ADD, a: 4'h7, b: 4'h1});
    wait_rsp(0);
    check("post_rst_result", {rsp_carry, rsp_zero, rsp_result}, {1'b0, 1'b0, 4'h8});
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
